// File: rtl/mac_speed_cfg_seq.sv
// Link-speed configuration sequencer: read-modify-write of the MAC config register
// (PS/FES bits) with read-back verify, bounded retries and a per-access timeout.
module mac_speed_cfg_seq #(
  parameter logic [13:0] P_CFG_ADDR = 14'h0000,
  parameter int unsigned P_PS_BIT   = 15,
  parameter int unsigned P_FES_BIT  = 14,
  parameter int unsigned P_TIMEOUT  = 1023,
  parameter int unsigned P_RETRY    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_speed,
  input  logic        i_speed_valid,
  output logic [13:0] o_mac_addr,
  output logic [31:0] o_mac_wr_data,
  output logic        o_mac_rdwn,
  output logic        o_mac_request,
  input  logic        i_mac_done,
  input  logic [31:0] i_mac_rd_data,
  output logic        o_busy,
  output logic        o_cfg_done,
  output logic        o_cfg_err,
  output logic [1:0]  o_cur_speed
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned TMO_W   = 16;
  localparam int unsigned RETRY_W = (P_RETRY == 0) ? 1 : $clog2(P_RETRY + 1);

  localparam logic [DATA_W-1:0] MASK     = (DATA_W'(1) << P_PS_BIT) | (DATA_W'(1) << P_FES_BIT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(P_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(P_RETRY);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_MODIFY,
    S_WR_REQ,
    S_WR_WAIT,
    S_VFY_REQ,
    S_VFY_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  // PS/FES pattern a given speed code must leave in the register
  function automatic logic [DATA_W-1:0] target_bits(input logic [1:0] spd);
    logic [DATA_W-1:0] t;
    t = '0;
    case (spd)
      2'b00:   t[P_PS_BIT] = 1'b1;
      2'b01: begin
        t[P_PS_BIT]  = 1'b1;
        t[P_FES_BIT] = 1'b1;
      end
      default: t = '0;
    endcase
    return t;
  endfunction

  state_e              state_q, state_d;
  logic [1:0]          speed_q, speed_d;
  logic                pend_q, pend_d;
  logic [1:0]          pend_speed_q, pend_speed_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                rdwn_q, rdwn_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                cfg_done_q, cfg_done_d;
  logic                cfg_err_q, cfg_err_d;
  logic [1:0]          cur_speed_q, cur_speed_d;

  logic [DATA_W-1:0]   tgt;
  logic [DATA_W-1:0]   new_val;
  logic [1:0]          sel_speed;
  logic                tmo_hit;
  logic                fin_ok;
  logic                fin_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      speed_q      <= 2'b10;
      pend_q       <= 1'b0;
      pend_speed_q <= 2'b00;
      retry_q      <= '0;
      tmo_q        <= '0;
      rd_q         <= '0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      rdwn_q       <= 1'b1;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      cur_speed_q  <= 2'b10;
    end else begin
      state_q      <= state_d;
      speed_q      <= speed_d;
      pend_q       <= pend_d;
      pend_speed_q <= pend_speed_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      rdwn_q       <= rdwn_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      cfg_done_q   <= cfg_done_d;
      cfg_err_q    <= cfg_err_d;
      cur_speed_q  <= cur_speed_d;
    end
  end

  // Status pulses are set on the transition so they coincide with the DONE/ERR state
  always_comb begin
    state_d      = state_q;
    speed_d      = speed_q;
    pend_d       = pend_q;
    pend_speed_d = pend_speed_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    rdwn_d       = rdwn_q;
    req_d        = 1'b0;
    busy_d       = busy_q;
    cfg_done_d   = 1'b0;
    cfg_err_d    = 1'b0;
    cur_speed_d  = cur_speed_q;
    fin_ok       = 1'b0;
    fin_err      = 1'b0;

    tgt       = target_bits(speed_q);
    new_val   = (rd_q & ~MASK) | tgt;
    sel_speed = i_speed_valid ? i_speed : pend_speed_q;
    tmo_hit   = (tmo_q == TMO_LAST);

    if (i_speed_valid && (state_q != S_IDLE)) begin
      pend_d       = 1'b1;
      pend_speed_d = i_speed;
    end

    case (state_q)
      S_IDLE: begin
        if (i_speed_valid || pend_q) begin
          pend_d  = 1'b0;
          speed_d = sel_speed;
          if (sel_speed == 2'b11) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = S_RD_REQ;
            busy_d  = 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        addr_d  = P_CFG_ADDR;
        rdwn_d  = 1'b1;
        req_d   = 1'b1;
        tmo_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i_mac_done) begin
          rd_d    = i_mac_rd_data;
          state_d = S_MODIFY;
        end else if (tmo_hit) begin
          fin_err = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_MODIFY: begin
        if ((rd_q & MASK) == tgt) begin
          fin_ok = 1'b1;
        end else begin
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        rdwn_d    = 1'b0;
        wr_data_d = new_val;
        req_d     = 1'b1;
        tmo_d     = '0;
        state_d   = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (i_mac_done) begin
          state_d = S_VFY_REQ;
        end else if (tmo_hit) begin
          fin_err = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_VFY_REQ: begin
        rdwn_d  = 1'b1;
        req_d   = 1'b1;
        tmo_d   = '0;
        state_d = S_VFY_WAIT;
      end
      S_VFY_WAIT: begin
        if (i_mac_done) begin
          if ((i_mac_rd_data & MASK) == tgt) begin
            fin_ok = 1'b1;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_WR_REQ;
          end else begin
            fin_err = 1'b1;
          end
        end else if (tmo_hit) begin
          fin_err = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fin_ok) begin
      state_d     = S_DONE;
      cfg_done_d  = 1'b1;
      busy_d      = 1'b0;
      retry_d     = '0;
      cur_speed_d = speed_q;
    end
    if (fin_err) begin
      state_d   = S_ERR;
      cfg_err_d = 1'b1;
      busy_d    = 1'b0;
      retry_d   = '0;
    end
  end

  assign o_mac_addr    = addr_q;
  assign o_mac_wr_data = wr_data_q;
  assign o_mac_rdwn    = rdwn_q;
  assign o_mac_request = req_q;
  assign o_busy        = busy_q;
  assign o_cfg_done    = cfg_done_q;
  assign o_cfg_err     = cfg_err_q;
  assign o_cur_speed   = cur_speed_q;

endmodule

// File: doc/mac_speed_cfg_seq.md
Name: mac_speed_cfg_seq

Overview:
- Upstream sequencer that drives the MAC register-access request/done handshake.
- On a link-speed event it performs a read-modify-write of the MAC configuration register. It sets the port-select (PS) and fast-ethernet-speed (FES) bits, then reads the register back to verify.
- It retries on verify mismatch, times out on a missing done, and reports the speed that was applied.

Parameters:
- P_CFG_ADDR, 14'h0000, address of the MAC configuration register.
- P_PS_BIT, 15, bit index of PS (1 = MII 10/100, 0 = GMII 1000).
- P_FES_BIT, 14, bit index of FES (1 = 100M, 0 = 10M).
- P_TIMEOUT, 1023, maximum cycles to wait for i_mac_done per access (1..65535).
- P_RETRY, 2, number of extra write+verify attempts after a mismatch.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_speed  in  2  requested speed: 00 = 10M, 01 = 100M, 10 = 1000M, 11 = reserved.
- i_speed_valid  in  1  one-cycle strobe qualifying i_speed.
- o_mac_addr  out  14  register address to the access stage.
- o_mac_wr_data  out  32  write data to the access stage.
- o_mac_rdwn  out  1  1 = read, 0 = write.
- o_mac_request  out  1  one-cycle access request pulse.
- i_mac_done  in  1  one-cycle access completion pulse.
- i_mac_rd_data  in  32  read data, valid in the i_mac_done cycle.
- o_busy  out  1  high from accepting a strobe until DONE or ERR.
- o_cfg_done  out  1  one-cycle success pulse.
- o_cfg_err  out  1  one-cycle failure pulse.
- o_cur_speed  out  2  last successfully applied speed.

Behaviour:
- Reset (synchronous, active-low): FSM to IDLE.
  - o_mac_request = 0, o_mac_addr = 0, o_mac_wr_data = 0, o_mac_rdwn = 1.
  - o_busy = 0, o_cfg_done = 0, o_cfg_err = 0, o_cur_speed = 2'b10.
  - Pending flag, retry counter and timeout counter = 0.
- All outputs are registered.
- Handshake rules:
  - o_mac_request is high for exactly one cycle.
  - o_mac_addr, o_mac_wr_data and o_mac_rdwn are driven one cycle before or with the request and held stable until i_mac_done.
  - Never more than one outstanding access.
  - i_mac_done outside a WAIT state is ignored.
- Target bits:
  - 10M: PS = 1, FES = 0.
  - 100M: PS = 1, FES = 1.
  - 1000M: PS = 0, FES = 0.
  - MASK = (1 << P_PS_BIT) | (1 << P_FES_BIT).
  - new = (rd & ~MASK) | target.
- FSM states:
  - IDLE: on i_speed_valid (or pending set) latch the speed.
    - Reserved code 11: pulse o_cfg_err next cycle, no bus access, stay IDLE.
    - Otherwise go to RD_REQ and set o_busy.
  - RD_REQ: address = P_CFG_ADDR, rdwn = 1, pulse request, go to RD_WAIT.
  - RD_WAIT: on done capture rd_data and go to MODIFY.
  - MODIFY: compute new.
    - If (rd & MASK) == target, skip the write and go to DONE (no write issued).
    - Otherwise go to WR_REQ.
  - WR_REQ: rdwn = 0, wr_data = new, pulse request, go to WR_WAIT.
  - WR_WAIT: on done go to VFY_REQ.
  - VFY_REQ: rdwn = 1, pulse request, go to VFY_WAIT.
  - VFY_WAIT: on done compare (rd_data & MASK) with target.
    - Match: go to DONE.
    - Mismatch with retry counter < P_RETRY: increment the counter and go to WR_REQ.
    - Otherwise go to ERR.
  - DONE: pulse o_cfg_done, o_cur_speed = latched speed, clear o_busy and the retry counter, go to IDLE.
  - ERR: pulse o_cfg_err, o_cur_speed unchanged, clear o_busy and the retry counter, go to IDLE.
- Timeout:
  - 16-bit counter, cleared on entry to each WAIT state, increments each WAIT cycle without done.
  - Reaching P_TIMEOUT goes to ERR.
  - Done in the same cycle the counter reaches P_TIMEOUT counts as done; done has priority.
- i_speed_valid while busy:
  - Sets the one-deep pending flag; the latest i_speed overwrites the pending value.
  - The current sequence is not aborted.
  - The pending request starts from IDLE the cycle after DONE or ERR.
- i_speed_valid in the DONE or ERR cycle is treated as pending.
- Reset mid-sequence: immediate return to IDLE with request low.
  - The access stage shares the reset, so no orphan transaction remains.
  - A stray done after reset is ignored.
- Latency, with done returning N cycles after each request:
  - Read plus write skipped: ~ N + 4 cycles from strobe to o_cfg_done.
  - Full read, write and verify: ~ 3N + 8 cycles.

Test Plan:
- rd_data = 32'h0000_8C00, strobe 1000M → write 32'h0000_0C00, verify reads 32'h0000_0C00, o_cfg_done = 1, o_cur_speed = 10.
- Current 1000M, rd_data = 32'h0000_0000, strobe 100M → write 32'h0000_C000, verify matches, o_cfg_done, o_cur_speed = 01.
- rd_data already 32'h0000_8000, strobe 10M → no write request issued, o_cfg_done after a single read.
- Verify always returns 32'h0 for 100M → 3 writes (1 + P_RETRY), then o_cfg_err, o_cur_speed unchanged.
- Done withheld after the read → o_cfg_err exactly 1023 cycles after the request; a late done is ignored. Also: i_speed = 11 → o_cfg_err, no request.
- Strobe 10M then 100M during RD_WAIT → first sequence completes (done, o_cur_speed = 00), second starts the next cycle and ends with o_cur_speed = 01. Also: reset asserted in WR_WAIT → all outputs at reset values the next cycle.
